// File: rtl/instruction_fetch.sv
// Purpose: instruction fetch stage; one outstanding imem request, delivers instruction + (pc+4) to IF/ID.
// Latency: delivery is combinational in the cycle imem_rvalid arrives; one request cycle plus the memory latency per instruction.
// Backpressure: imem_ready stalls the request; freeze drops the response for a refetch, or parks it in a hold buffer when IF_HOLD_BUF_EN is defined.
`ifndef WORD
`define WORD 32
`endif

module instruction_fetch #(
    parameter logic [`WORD-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [`WORD-1:0]   branch_target,
    output logic               imem_req,
    output logic [`WORD-1:0]   imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [`WORD-1:0]   imem_rdata,
    output logic [`WORD-1:0]   PC_out,
    output logic [`WORD-1:0]   instruction_out,
    output logic               flush_out
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [`WORD-1:0]   pc_q, pc_d;
    logic               discard_q, discard_d;
`ifdef IF_HOLD_BUF_EN
    logic [`WORD-1:0]   hold_q, hold_d;
`endif

    logic [`WORD-1:0]   pc_inc;
    logic [`WORD-1:0]   target_aligned;

    // Sequential pc increment wraps naturally at the word width.
    assign pc_inc         = pc_q + `WORD'(4);
    assign target_aligned = {branch_target[`WORD-1:2], 2'b00};
    assign imem_addr      = pc_q;

    // Next-state and output decode; branch_taken overrides everything else.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        discard_d       = discard_q;
`ifdef IF_HOLD_BUF_EN
        hold_d          = hold_q;
`endif
        imem_req        = 1'b0;
        PC_out          = '0;
        instruction_out = '0;
        flush_out       = 1'b0;

        case (state_q)
            S_REQ: begin
                // Responses arriving here belong to a killed request and are ignored.
                if (branch_taken) begin
                    flush_out = 1'b1;
                    pc_d      = target_aligned;
                end else begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (branch_taken) begin
                    flush_out = 1'b1;
                    pc_d      = target_aligned;
                    if (imem_rvalid) begin
                        // Response shows up alongside the redirect: drop it here.
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end else begin
                        // Request still in flight: remember to drop its response.
                        discard_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    state_d = S_REQ;
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else if (freeze) begin
`ifdef IF_HOLD_BUF_EN
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
`else
                        // No buffer: pc is left alone so the same address is refetched.
                        state_d = S_REQ;
`endif
                    end else begin
                        instruction_out = imem_rdata;
                        PC_out          = pc_inc;
                        pc_d            = pc_inc;
                    end
                end
            end

            S_HOLD: begin
`ifdef IF_HOLD_BUF_EN
                if (branch_taken) begin
                    flush_out = 1'b1;
                    pc_d      = target_aligned;
                    hold_d    = '0;
                    state_d   = S_REQ;
                end else if (!freeze) begin
                    instruction_out = hold_q;
                    PC_out          = pc_inc;
                    pc_d            = pc_inc;
                    hold_d          = '0;
                    state_d         = S_REQ;
                end
`else
                state_d = S_REQ;
`endif
            end

            default: begin
                state_d = S_REQ;
            end
        endcase

        // Reset holds all stage outputs quiet.
        if (rst) begin
            imem_req        = 1'b0;
            PC_out          = '0;
            instruction_out = '0;
            flush_out       = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
`ifdef IF_HOLD_BUF_EN
            hold_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
`ifdef IF_HOLD_BUF_EN
            hold_q    <= hold_d;
`endif
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch (default build, no hold buffer), RESET_PC = 0x100.
// Per-cycle vector table for the main sequences, then a 3-cycle-latency memory loop.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] PC_out;
    logic [31:0] instruction_out;
    logic        flush_out;

    int checks = 0;
    int errors = 0;

    instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .PC_out          (PC_out),
        .instruction_out (instruction_out),
        .flush_out       (flush_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        frz;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        ca;   // compare imem_addr this cycle
        logic        er;
        logic [31:0] ea;
        logic [31:0] ep;
        logic [31:0] ei;
        logic        ef;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic f, input logic b, input logic [31:0] t,
                       input logic rdy, input logic rv, input logic [31:0] rd, input logic ca,
                       input logic er, input logic [31:0] ea, input logic [31:0] ep,
                       input logic [31:0] ei, input logic ef);
        vec_t v;
        v.rst = r; v.frz = f; v.br = b; v.tgt = t; v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.ca = ca; v.er = er; v.ea = ea; v.ep = ep; v.ei = ei; v.ef = ef;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] got_addr;
        // latency-loop model state
        logic        outst;
        int          cnt;
        logic [31:0] req_addr;
        logic [31:0] next_addr;
        int          delivered;

        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_target = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

        //   rst frz br tgt           rdy rv rd            ca  req addr          pc_out        instr         flush
        // reset
        add(1, 0, 0, 32'h0,        0, 0, 32'h0,        0,  0, 32'h0,        32'h0,        32'h0,        0);
        add(1, 0, 0, 32'h0,        0, 0, 32'h0,        1,  0, 32'h100,      32'h0,        32'h0,        0);
        // 1-cycle memory: 0x100, 0x104, 0x108
        add(0, 0, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h100,      32'h0,        32'h0,        0);
        add(0, 0, 0, 32'h0,        0, 1, 32'hAAAA0001, 1,  0, 32'h100,      32'h104,      32'hAAAA0001, 0);
        add(0, 0, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h104,      32'h0,        32'h0,        0);
        add(0, 0, 0, 32'h0,        0, 1, 32'hAAAA0002, 1,  0, 32'h104,      32'h108,      32'hAAAA0002, 0);
        add(0, 0, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h108,      32'h0,        32'h0,        0);
        add(0, 0, 0, 32'h0,        0, 1, 32'hAAAA0003, 1,  0, 32'h108,      32'h10C,      32'hAAAA0003, 0);
        // branch in S_WAIT before the response: stale response dropped, target aligned
        add(0, 0, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h10C,      32'h0,        32'h0,        0);
        add(0, 0, 1, 32'h203,      0, 0, 32'h0,        1,  0, 32'h10C,      32'h0,        32'h0,        1);
        add(0, 0, 0, 32'h0,        0, 1, 32'hDEAD0000, 1,  0, 32'h200,      32'h0,        32'h0,        0);
        add(0, 0, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h200,      32'h0,        32'h0,        0);
        add(0, 0, 0, 32'h0,        0, 1, 32'hAAAA0004, 1,  0, 32'h200,      32'h204,      32'hAAAA0004, 0);
        // branch together with rvalid: response dropped, no lingering discard
        add(0, 0, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h204,      32'h0,        32'h0,        0);
        add(0, 0, 1, 32'h300,      0, 1, 32'hBAD00000, 1,  0, 32'h204,      32'h0,        32'h0,        1);
        add(0, 0, 0, 32'h0,        0, 0, 32'h0,        1,  1, 32'h300,      32'h0,        32'h0,        0);
        add(0, 0, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h300,      32'h0,        32'h0,        0);
        add(0, 0, 0, 32'h0,        0, 1, 32'hAAAA0005, 1,  0, 32'h300,      32'h304,      32'hAAAA0005, 0);
        // freeze while the response arrives: dropped, same address requested again
        add(0, 0, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h304,      32'h0,        32'h0,        0);
        add(0, 1, 0, 32'h0,        0, 1, 32'hAAAA0006, 1,  0, 32'h304,      32'h0,        32'h0,        0);
        add(0, 1, 0, 32'h0,        0, 0, 32'h0,        1,  1, 32'h304,      32'h0,        32'h0,        0);
        add(0, 1, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h304,      32'h0,        32'h0,        0);
        add(0, 0, 0, 32'h0,        0, 1, 32'hAAAA0006, 1,  0, 32'h304,      32'h308,      32'hAAAA0006, 0);
        // rvalid in S_REQ ignored
        add(0, 0, 0, 32'h0,        0, 1, 32'h77777777, 1,  1, 32'h308,      32'h0,        32'h0,        0);
        // reset while waiting; late response ignored, fetch restarts at RESET_PC
        add(0, 0, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h308,      32'h0,        32'h0,        0);
        add(1, 0, 0, 32'h0,        0, 0, 32'h0,        1,  0, 32'h308,      32'h0,        32'h0,        0);
        add(0, 0, 0, 32'h0,        0, 1, 32'h88888888, 1,  1, 32'h100,      32'h0,        32'h0,        0);
        // branch in S_REQ to the last word, then wrap
        add(0, 0, 1, 32'hFFFFFFFF, 0, 0, 32'h0,        1,  0, 32'h100,      32'h0,        32'h0,        1);
        add(0, 0, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'hFFFFFFFC, 32'h0,        32'h0,        0);
        add(0, 0, 0, 32'h0,        0, 1, 32'hAAAA0009, 1,  0, 32'hFFFFFFFC, 32'h0,        32'hAAAA0009, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h0,        1,  1, 32'h0,        32'h0,        32'h0,        0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; freeze = vecs[i].frz; branch_taken = vecs[i].br;
            branch_target = vecs[i].tgt; imem_ready = vecs[i].rdy;
            imem_rvalid = vecs[i].rv; imem_rdata = vecs[i].rd;
            #1;
            got_addr = vecs[i].ca ? imem_addr : vecs[i].ea;
            checks++;
            if ({imem_req, got_addr, PC_out, instruction_out, flush_out} !==
                {vecs[i].er, vecs[i].ea, vecs[i].ep, vecs[i].ei, vecs[i].ef}) begin
                errors++;
                $display("FAIL vec%0d: got req=%b addr=%h pc_out=%h instr=%h flush=%b, need req=%b addr=%h pc_out=%h instr=%h flush=%b",
                         i, imem_req, imem_addr, PC_out, instruction_out, flush_out,
                         vecs[i].er, vecs[i].ea, vecs[i].ep, vecs[i].ei, vecs[i].ef);
            end
        end

        // 3-cycle response latency, memory always ready; pc starts at 0 in S_REQ.
        outst = 1'b0; cnt = 0; req_addr = '0; next_addr = 32'h0; delivered = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_target = '0;
            imem_ready = 1'b1;
            if (outst) cnt--;
            imem_rvalid = outst && (cnt == 0);
            imem_rdata  = req_addr ^ 32'hC0DE0000;
            #1;
            checks++;
            if (imem_req && outst) begin
                errors++;
                $display("FAIL lat_inflight c%0d: got req=1 while a request is outstanding, need req=0", c);
            end
            if (imem_req) begin
                checks++;
                if (imem_addr !== next_addr) begin
                    errors++;
                    $display("FAIL lat_addr c%0d: got addr=%h, need %h", c, imem_addr, next_addr);
                end
            end
            checks++;
            if (imem_rvalid) begin
                if (instruction_out !== (req_addr ^ 32'hC0DE0000) || PC_out !== req_addr + 32'd4) begin
                    errors++;
                    $display("FAIL lat_deliver c%0d: got instr=%h pc_out=%h, need instr=%h pc_out=%h",
                             c, instruction_out, PC_out, req_addr ^ 32'hC0DE0000, req_addr + 32'd4);
                end
            end else if (instruction_out !== 32'h0 || PC_out !== 32'h0) begin
                errors++;
                $display("FAIL lat_bubble c%0d: got instr=%h pc_out=%h, need 0 and 0", c, instruction_out, PC_out);
            end
            @(posedge clk);
            if (imem_rvalid) begin
                outst = 1'b0;
                delivered++;
                next_addr = next_addr + 32'd4;
            end
            if (imem_req && imem_ready) begin
                outst = 1'b1;
                cnt = 3;
                req_addr = imem_addr;
            end
        end
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_ready  = 1'b0;
        checks++;
        if (delivered != 4) begin
            errors++;
            $display("FAIL lat_count: got %0d deliveries, need 4", delivered);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
